// File: rtl/long_div_signed_ctl_pkg.sv
// Shared mul_div definitions: divide op encodings, one-hot FSM state indices and op decode helpers.
package long_div_signed_ctl_pkg;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  localparam int ST_IDLE_IDX   = 0;
  localparam int ST_LAUNCH_IDX = 1;
  localparam int ST_WAIT_IDX   = 2;
  localparam int ST_FIXUP_IDX  = 3;
  localparam int ST_OUTPUT_IDX = 4;
  localparam int NUM_STATES    = 5;

  typedef enum logic [NUM_STATES-1:0] {
    S_IDLE   = 5'(1 << ST_IDLE_IDX),
    S_LAUNCH = 5'(1 << ST_LAUNCH_IDX),
    S_WAIT   = 5'(1 << ST_WAIT_IDX),
    S_FIXUP  = 5'(1 << ST_FIXUP_IDX),
    S_OUTPUT = 5'(1 << ST_OUTPUT_IDX)
  } state_t;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
  endfunction

endpackage

// File: rtl/long_div_signed_ctl_div_sign_fixup.sv
// Combinational sign correction of the unsigned core result, with the
// divide-by-zero and signed-overflow overrides taking priority.
module div_sign_fixup
  import long_div_signed_ctl_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]            op,
  input  logic                  sa,
  input  logic                  sb,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  input  logic [DATA_WIDTH-1:0] quotient,
  input  logic [DATA_WIDTH-1:0] remainder,
  output logic [DATA_WIDTH-1:0] result
);

  localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic is_rem;
  logic div_zero;
  logic overflow;

  assign is_rem   = op_is_rem(op);
  assign div_zero = (divisor == '0);
  assign overflow = op_is_signed(op) && (dividend == MIN_NEG) && (divisor == '1);

  always_comb begin
    result = is_rem ? (sa ? -remainder : remainder)
                    : ((sa ^ sb) ? -quotient : quotient);
    // Corner cases never depend on what the core returned.
    if (div_zero) begin
      result = is_rem ? dividend : '1;
    end else if (overflow) begin
      result = is_rem ? '0 : MIN_NEG;
    end
  end

endmodule

// File: rtl/long_div_signed_ctl.sv
// Signed/unsigned front-end for the multi-cycle unsigned long divider core.
// Build option DIV_FAST_PATH_EN: resolve divide-by-zero and signed overflow without launching the core.
//
// state    | meaning
// S_IDLE   | waiting for enable_in; operands and magnitudes latched on accept
// S_LAUNCH | core_enable_out pulse to the divider core
// S_WAIT   | waiting for core_enable_in; quotient/remainder captured
// S_FIXUP  | sign-corrected result registered
// S_OUTPUT | enable_out pulse, result valid
module long_div_signed_ctl
  import long_div_signed_ctl_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable_in,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  enable_out,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  busy,
  output logic                  core_enable_out,
  output logic [DATA_WIDTH-1:0] core_numerator,
  output logic [DATA_WIDTH-1:0] core_denominator,
  input  logic                  core_enable_in,
  input  logic [DATA_WIDTH-1:0] core_quotient,
  input  logic [DATA_WIDTH-1:0] core_remainder
);

  state_t                state;
  logic [1:0]            op_q;
  logic                  sa_q;
  logic                  sb_q;
  logic [DATA_WIDTH-1:0] dividend_q;
  logic [DATA_WIDTH-1:0] divisor_q;
  logic [DATA_WIDTH-1:0] quot_q;
  logic [DATA_WIDTH-1:0] rem_q;
  logic [DATA_WIDTH-1:0] fixed_result;

  logic                  in_signed;
  logic                  in_sa;
  logic                  in_sb;
  logic [DATA_WIDTH-1:0] in_num_mag;
  logic [DATA_WIDTH-1:0] in_den_mag;

  assign in_signed  = op_is_signed(op);
  assign in_sa      = dividend[DATA_WIDTH-1] & in_signed;
  assign in_sb      = divisor[DATA_WIDTH-1] & in_signed;
  // Most negative value negates to itself, which is its correct unsigned magnitude.
  assign in_num_mag = in_sa ? -dividend : dividend;
  assign in_den_mag = in_sb ? -divisor : divisor;

`ifdef DIV_FAST_PATH_EN
  localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  logic in_corner;
  assign in_corner = (divisor == '0) ||
                     (in_signed && (dividend == MIN_NEG) && (divisor == '1));
`endif

  div_sign_fixup #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fixup (
    .op        (op_q),
    .sa        (sa_q),
    .sb        (sb_q),
    .dividend  (dividend_q),
    .divisor   (divisor_q),
    .quotient  (quot_q),
    .remainder (rem_q),
    .result    (fixed_result)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= S_IDLE;
      op_q             <= '0;
      sa_q             <= 1'b0;
      sb_q             <= 1'b0;
      dividend_q       <= '0;
      divisor_q        <= '0;
      quot_q           <= '0;
      rem_q            <= '0;
      result           <= '0;
      enable_out       <= 1'b0;
      busy             <= 1'b0;
      core_enable_out  <= 1'b0;
      core_numerator   <= '0;
      core_denominator <= '0;
    end else begin
      enable_out      <= 1'b0;
      core_enable_out <= 1'b0;
      case (state)
        S_IDLE: begin
          if (enable_in) begin
            op_q             <= op;
            sa_q             <= in_sa;
            sb_q             <= in_sb;
            dividend_q       <= dividend;
            divisor_q        <= divisor;
            core_numerator   <= in_num_mag;
            core_denominator <= in_den_mag;
            busy             <= 1'b1;
`ifdef DIV_FAST_PATH_EN
            if (in_corner) begin
              state <= S_FIXUP;
            end else begin
              state           <= S_LAUNCH;
              core_enable_out <= 1'b1;
            end
`else
            state           <= S_LAUNCH;
            core_enable_out <= 1'b1;
`endif
          end
        end
        S_LAUNCH: state <= S_WAIT;
        S_WAIT: begin
          if (core_enable_in) begin
            quot_q <= core_quotient;
            rem_q  <= core_remainder;
            state  <= S_FIXUP;
          end
        end
        S_FIXUP: begin
          result     <= fixed_result;
          enable_out <= 1'b1;
          state      <= S_OUTPUT;
        end
        S_OUTPUT: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_long_div_signed_ctl.sv
// Directed bench for long_div_signed_ctl with an arithmetic reference model and a behavioural divider core.
module tb_long_div_signed_ctl;

  logic        clk;
  logic        reset_n;
  logic        enable_in;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        enable_out;
  logic [31:0] result;
  logic        busy;
  logic        core_enable_out;
  logic [31:0] core_numerator;
  logic [31:0] core_denominator;
  logic        core_enable_in;
  logic [31:0] core_quotient;
  logic [31:0] core_remainder;

  long_div_signed_ctl #(.DATA_WIDTH(32)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .enable_in        (enable_in),
    .op               (op),
    .dividend         (dividend),
    .divisor          (divisor),
    .enable_out       (enable_out),
    .result           (result),
    .busy             (busy),
    .core_enable_out  (core_enable_out),
    .core_numerator   (core_numerator),
    .core_denominator (core_denominator),
    .core_enable_in   (core_enable_in),
    .core_quotient    (core_quotient),
    .core_remainder   (core_remainder)
  );

  int          assertions = 0;
  int          errors     = 0;
  int          cyc        = 0;
  int          launches   = 0;
  int          core_lat   = 1;
  int          resp_cnt   = 0;
  logic [31:0] exp_num    = '0;
  logic [31:0] exp_den    = '0;
  logic [31:0] resp_q     = '0;
  logic [31:0] resp_r     = '0;
  logic [31:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RISC-V division semantics from plain integer arithmetic
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int si;
    int di;
    bit sgn;
    bit rem;
    sgn = !o[0];
    rem = o[1];
    if (b == 32'h0) return rem ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'h0 : 32'h8000_0000;
    if (sgn) begin
      si = a;
      di = b;
      return rem ? 32'(si % di) : 32'(si / di);
    end
    return rem ? (a % b) : (a / b);
  endfunction

  function automatic bit is_corner(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'h0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] mag(input logic [31:0] x, input bit sgn);
    longint v;
    if (!sgn) return x;
    v = longint'($signed(x));
    if (v < 0) v = -v;
    return v[31:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Behavioural divider core: answers L cycles after each launch.
  initial begin
    core_enable_in = 1'b0;
    core_quotient  = '0;
    core_remainder = '0;
    forever begin
      @(negedge clk);
      core_enable_in = 1'b0;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          core_enable_in = 1'b1;
          core_quotient  = resp_q;
          core_remainder = resp_r;
        end
      end
      if (core_enable_out) begin
        launches++;
        chk("core_numerator", core_numerator, exp_num);
        chk("core_denominator", core_denominator, exp_den);
        resp_cnt = core_lat;
        if (exp_den != 0) begin
          resp_q = exp_num / exp_den;
          resp_r = exp_num % exp_den;
        end else begin
          resp_q = 32'hA5A5_A5A5;
          resp_r = 32'h5A5A_5A5A;
        end
      end
    end
  end

  // Compare every completion against the model queue.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (reset_n && enable_out) begin
        assertions++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL spurious_enable_out: got result %h, expected no completion", result);
        end else begin
          e = exp_q.pop_front();
          if (result !== e) begin
            errors++;
            $display("FAIL model_result: got %h, expected %h", result, e);
          end
        end
      end
    end
  end

  task automatic run_req(input string name, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int lat, input logic [31:0] lit,
                         input int inject_at);
    int t0;
    int n_launch0;
    int exp_lat;
    int exp_launch;
    logic [31:0] e;
    @(negedge clk);
    chk({name, "_idle_busy"}, 32'(busy), 32'h0);
    e = model(o, a, b);
    chk({name, "_model_pin"}, e, lit);
    exp_lat    = lat + 3;
    exp_launch = 1;
`ifdef DIV_FAST_PATH_EN
    if (is_corner(o, a, b)) begin
      exp_lat    = 2;
      exp_launch = 0;
    end
`endif
    exp_num   = mag(a, !o[0]);
    exp_den   = mag(b, !o[0]);
    core_lat  = lat;
    exp_q.push_back(e);
    n_launch0 = launches;
    t0        = cyc;
    enable_in = 1'b1;
    op        = o;
    dividend  = a;
    divisor   = b;
    @(negedge clk);
    enable_in = 1'b0;
    op        = 2'($urandom);
    dividend  = $urandom;
    divisor   = $urandom;
    while (!enable_out && (cyc - t0) < 200) begin
      @(negedge clk);
      enable_in = (inject_at != 0) && ((cyc - t0) == inject_at);
    end
    enable_in = 1'b0;
    if (!enable_out) begin
      assertions++;
      errors++;
      $display("FAIL %s_timeout: got no enable_out within 200 cycles, expected one", name);
    end else begin
      chk({name, "_latency"}, 32'(cyc - t0), 32'(exp_lat));
      chk({name, "_result"}, result, lit);
      chk({name, "_busy"}, 32'(busy), 32'h1);
      chk({name, "_launches"}, 32'(launches - n_launch0), 32'(exp_launch));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n   = 1'b0;
    enable_in = 1'b0;
    op        = 2'b00;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(negedge clk);
    chk("rst_enable_out", 32'(enable_out), 32'h0);
    chk("rst_result", result, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_core_enable_out", 32'(core_enable_out), 32'h0);
    chk("rst_core_numerator", core_numerator, 32'h0);
    chk("rst_core_denominator", core_denominator, 32'h0);
    reset_n = 1'b1;

    run_req("div_m7_2",     2'b00, 32'hFFFF_FFF9, 32'h2,         3, 32'hFFFF_FFFD, 0);
    run_req("rem_m7_2",     2'b10, 32'hFFFF_FFF9, 32'h2,         1, 32'hFFFF_FFFF, 0);
    run_req("divu_big",     2'b01, 32'hFFFF_FFFF, 32'h10,        5, 32'h0FFF_FFFF, 0);
    run_req("div_ovf",      2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 2, 32'h8000_0000, 0);
    run_req("rem_ovf",      2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 2, 32'h0,         0);
    run_req("rem_by_zero",  2'b10, 32'h1234_5678, 32'h0,         4, 32'h1234_5678, 0);
    run_req("div_by_zero",  2'b00, 32'h1234_5678, 32'h0,         4, 32'hFFFF_FFFF, 0);
    run_req("remu_by_zero", 2'b11, 32'hDEAD_BEEF, 32'h0,         1, 32'hDEAD_BEEF, 0);
    run_req("divu_by_zero", 2'b01, 32'hDEAD_BEEF, 32'h0,         1, 32'hFFFF_FFFF, 0);
    run_req("divu_100_7",   2'b01, 32'd100,       32'd7,         2, 32'd14,        0);
    run_req("remu_100_7",   2'b11, 32'd100,       32'd7,         2, 32'd2,         0);
    run_req("div_100_m7",   2'b00, 32'd100,       32'hFFFF_FFF9, 3, 32'hFFFF_FFF2, 0);
    run_req("rem_m100_7",   2'b10, 32'hFFFF_FF9C, 32'd7,         3, 32'hFFFF_FFFE, 0);
    run_req("divu_min_m1",  2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0,         0);
    run_req("remu_min_m1",  2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 0);
    run_req("div_min_2",    2'b00, 32'h8000_0000, 32'h2,         2, 32'hC000_0000, 0);
    run_req("inject_wait",  2'b00, 32'hFFFF_FF9C, 32'hFFFF_FFF6, 6, 32'd10,        3);

    // Abort a request in S_WAIT; the core's late answer must be ignored.
    @(negedge clk);
    exp_num   = 32'd100;
    exp_den   = 32'd7;
    core_lat  = 10;
    enable_in = 1'b1;
    op        = 2'b01;
    dividend  = 32'd100;
    divisor   = 32'd7;
    @(negedge clk);
    enable_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_busy_before", 32'(busy), 32'h1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("abort_rst_busy", 32'(busy), 32'h0);
    chk("abort_rst_result", result, 32'h0);
    chk("abort_rst_core_numerator", core_numerator, 32'h0);
    reset_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("abort_busy_after", 32'(busy), 32'h0);
    run_req("after_abort",  2'b10, 32'd100,       32'hFFFF_FFF9, 2, 32'd2,         0);

    repeat (5) @(negedge clk);
    chk("pending_expectations", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, errors);
    $finish;
  end

endmodule
